// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache line refill sequencer and its
// one-hot word-select decoder.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Largest supported word-offset width (32 words per line).
  localparam int MAX_OFFSET_W = 5;

  // Words per cache line for a given word-offset width.
  function automatic int words_of(input int offset_w);
    return 1 << offset_w;
  endfunction

  // A zero-width offset is still carried on a 1-bit bus that is tied to 0.
  function automatic int idx_width(input int offset_w);
    return (offset_w == 0) ? 1 : offset_w;
  endfunction

  // Binary to one-hot over the widest supported line.
  function automatic logic [31:0] onehot_decode(input logic [MAX_OFFSET_W-1:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/onehot_decoder_n.sv
// Generic binary-to-one-hot decoder with enable; the parameterised
// replacement for the fixed 3-to-8 word-select decode.
module onehot_decoder_n
  import cache_fill_pkg::*;
#(
  parameter  int IN_W  = 3,
  localparam int OUT_W = words_of(IN_W),
  localparam int SEL_W = idx_width(IN_W)
) (
  input  logic             en,
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  logic [MAX_OFFSET_W-1:0] sel;

  // Decode the index; a single-word line always selects bit 0.
  always_comb begin
    sel    = (IN_W == 0) ? '0 : MAX_OFFSET_W'(idx);
    onehot = en ? OUT_W'(onehot_decode(sel)) : '0;
  end

endmodule

// File: rtl/cache_fill_sequencer.sv
// Cache line refill sequencer: walks the words of a line in
// critical-word-first (wrapping) or linear order and produces the
// data-array write enables for each accepted memory beat.
// Optional feature macro: CACHE_FILL_STALL_CNT_EN (stall cycle counter).
module cache_fill_sequencer
  import cache_fill_pkg::*;
#(
  parameter  int OFFSET_W = 3,
  parameter  int CNT_W    = 16,
  localparam int WORDS    = words_of(OFFSET_W),
  localparam int IDX_W    = idx_width(OFFSET_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] start_offset,
  input  logic             wrap_mode,
  input  logic             abort,
  input  logic             fill_valid,
  output logic             fill_ready,
  output logic [WORDS-1:0] word_en,
  output logic [IDX_W-1:0] word_idx,
  output logic             crit_word,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt
);

  // Beat counter must reach WORDS itself, hence one extra bit.
  localparam int BC_W = OFFSET_W + 1;

  fill_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, crit_q, idx_inc, load_idx, crit_load;
  logic [BC_W-1:0]  beat_q;
  logic             accept, last_beat;

  assign fill_ready = (state_q == FILL);
  assign busy       = (state_q == FILL);
  assign done       = (state_q == DONE);
  assign accept     = fill_valid & fill_ready;
  assign last_beat  = accept && (beat_q == BC_W'(WORDS - 1));
  assign word_idx   = idx_q;
  assign crit_word  = accept && (idx_q == crit_q);

  // Single-word lines keep the index pinned at zero; otherwise the natural
  // overflow of the index register gives the modulo-WORDS wrap.
  assign idx_inc   = (OFFSET_W == 0) ? '0 : idx_q + IDX_W'(1);
  assign load_idx  = (OFFSET_W == 0 || !wrap_mode) ? '0 : start_offset;
  assign crit_load = (OFFSET_W == 0) ? '0 : start_offset;

  onehot_decoder_n #(
    .IN_W (OFFSET_W)
  ) u_word_dec (
    .en     (accept),
    .idx    (idx_q),
    .onehot (word_en)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort takes priority over a coinciding last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (abort) state_d = IDLE;
               else if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word index, critical offset and beat count bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      crit_q <= '0;
      beat_q <= '0;
    end else if (state_q == IDLE && start) begin
      idx_q  <= load_idx;
      crit_q <= crit_load;
      beat_q <= '0;
    end else if (state_q == FILL && abort) begin
      idx_q  <= '0;
      beat_q <= '0;
    end else if (accept) begin
      idx_q  <= idx_inc;
      beat_q <= beat_q + BC_W'(1);
    end
  end

`ifdef CACHE_FILL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  // Count FILL cycles without a beat; saturate, hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (state_q == IDLE && start)
      stall_q <= '0;
    else if (state_q == FILL && !fill_valid && stall_q != '1)
      stall_q <= stall_q + CNT_W'(1);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
